// File: rtl/cmp_arbiter.sv
// Round-robin arbiter that shares one branch comparator between the branch unit and the
// ALU SLT/SLTU path; decodes branch funct3 and returns registered, single-pulse results.
module cmp_arbiter #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             br_valid,
   output logic             br_ready,
   input  logic [2:0]       br_funct3,
   input  logic [XLEN-1:0]  br_rs1,
   input  logic [XLEN-1:0]  br_rs2,
   output logic             br_resp_valid,
   output logic             br_taken,
   output logic             br_illegal,
   input  logic             slt_valid,
   output logic             slt_ready,
   input  logic             slt_uns,
   input  logic [XLEN-1:0]  slt_rs1,
   input  logic [XLEN-1:0]  slt_rs2,
   output logic             slt_resp_valid,
   output logic [XLEN-1:0]  slt_result,
   output logic [XLEN-1:0]  cmp_a,
   output logic [XLEN-1:0]  cmp_b,
   output logic             cmp_un,
   input  logic             cmp_eq,
   input  logic             cmp_lt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             dbgState
);

   typedef enum logic {IDLE = 1'b0, EVAL = 1'b1} state_t;

   state_t     state;
   logic       lastGrantSlt;
   logic       curIsSlt;
   logic [2:0] curFunct3;
   logic       isIdle;
   logic       brAccept;
   logic       sltAccept;
   logic       stallHit;
   logic       takenDec;
   logic       illegalDec;

   // Handshake: a request transfers on a cycle where valid & ready are both high. Ready is
   // a function of state, the other requester's valid and last_grant only, so a requester
   // may hold valid indefinitely; the two readies are never high together while both are valid.
   assign isIdle    = rst_n && (state == IDLE);
   assign br_ready  = isIdle && (!slt_valid || lastGrantSlt);
   assign slt_ready = isIdle && (!br_valid  || !lastGrantSlt);
   assign brAccept  = br_valid  && br_ready;
   assign sltAccept = slt_valid && slt_ready;
   assign stallHit  = (br_valid && !br_ready) || (slt_valid && !slt_ready);
   assign dbgState  = state;

   always_comb begin
      takenDec   = 1'b0;
      illegalDec = 1'b0;
      case (curFunct3)
         3'b000:          takenDec   = cmp_eq;
         3'b001:          takenDec   = !cmp_eq;
         3'b100, 3'b110:  takenDec   = cmp_lt;
         3'b101, 3'b111:  takenDec   = !cmp_lt;
         default:         illegalDec = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         lastGrantSlt   <= 1'b1;
         curIsSlt       <= 1'b0;
         curFunct3      <= 3'b000;
         cmp_a          <= '0;
         cmp_b          <= '0;
         cmp_un         <= 1'b0;
         br_resp_valid  <= 1'b0;
         br_taken       <= 1'b0;
         br_illegal     <= 1'b0;
         slt_resp_valid <= 1'b0;
         slt_result     <= '0;
         stall_cnt      <= '0;
      end else begin
         br_resp_valid  <= 1'b0;
         slt_resp_valid <= 1'b0;
         if (stallHit && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
         case (state)
            IDLE: begin
               if (brAccept) begin
                  cmp_a        <= br_rs1;
                  cmp_b        <= br_rs2;
                  cmp_un       <= br_funct3[1];
                  curIsSlt     <= 1'b0;
                  curFunct3    <= br_funct3;
                  lastGrantSlt <= 1'b0;
                  state        <= EVAL;
               end else if (sltAccept) begin
                  cmp_a        <= slt_rs1;
                  cmp_b        <= slt_rs2;
                  cmp_un       <= slt_uns;
                  curIsSlt     <= 1'b1;
                  lastGrantSlt <= 1'b1;
                  state        <= EVAL;
               end
            end
            EVAL: begin
               // Comparator outputs settle on the operands registered last cycle.
               if (curIsSlt) begin
                  slt_result     <= {{(XLEN-1){1'b0}}, cmp_lt};
                  slt_resp_valid <= 1'b1;
               end else begin
                  br_taken      <= takenDec;
                  br_illegal    <= illegalDec;
                  br_resp_valid <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
